// File: rtl/exp5_unidade_controle.sv
// Purpose : Moore control unit for one memory-game round. It clears the datapath,
//           waits for each play, registers and compares it, advances the address,
//           and finishes in hit, miss or timeout. It also owns the per-play timeout.
// Latency : outputs are decoded from the state register, so they change only after
//           a rising edge. A play sampled in espera_jogada gives registraR on the next cycle.
// Backpr. : none. The unit only reacts to level/pulse inputs and never stalls them.
//           jogada is dropped outside espera_jogada; iniciar is dropped mid-round.
// Ports   : clock, reset (sync, active-low), iniciar, jogada, igual, fim  -> inputs
//           zeraC, contaC, zeraR, registraR      -> datapath controls
//           pronto, acertou, errou, deu_timeout  -> round result
//           db_estado[3:0]                       -> state code for the HEX5 display
module exp5_unidade_controle #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       deu_timeout,
  output logic [3:0] db_estado
);

  // The counter only has to reach TIMEOUT-1. Keep at least 1 bit so the
  // declaration stays legal for the smallest allowed TIMEOUT.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  // The encodings double as the debug display codes, so db_estado is the raw state.
  typedef enum logic [3:0] {
    inicial       = 4'h0,
    preparacao    = 4'h1,
    espera_jogada = 4'h2,
    registra      = 4'h4,
    comparacao    = 4'h5,
    proximo       = 4'h6,
    fim_acerto    = 4'hA,
    fim_timeout   = 4'hD,
    fim_erro      = 4'hE
  } estado_t;

  estado_t       estado;
  estado_t       prox;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // State and timeout counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= inicial;
      cnt    <= '0;
    end else begin
      estado <= prox;
      cnt    <= cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    prox = estado;
    case (estado)
      inicial: begin
        if (iniciar) prox = preparacao;
      end
      preparacao: begin
        prox = espera_jogada;
      end
      espera_jogada: begin
        // A play in the last wait cycle still counts, so jogada is tested first.
        if (jogada)               prox = registra;
        else if (cnt == TMO_LAST) prox = fim_timeout;
      end
      registra: begin
        prox = comparacao;
      end
      comparacao: begin
        if (!igual)   prox = fim_erro;
        else if (fim) prox = fim_acerto;
        else          prox = proximo;
      end
      proximo: begin
        prox = espera_jogada;
      end
      fim_acerto, fim_erro, fim_timeout: begin
        if (iniciar) prox = preparacao;
      end
      default: begin
        // Unused codes fall back to idle.
        prox = inicial;
      end
    endcase
  end

  // The counter advances only while the unit stays in espera_jogada. It is
  // zero on entry to every wait and never has to represent TIMEOUT itself,
  // so it cannot wrap.
  always_comb begin
    cnt_next = '0;
    if (estado == espera_jogada && prox == espera_jogada) begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Moore output decode.
  always_comb begin
    zeraC       = 1'b0;
    contaC      = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    deu_timeout = 1'b0;
    case (estado)
      preparacao: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      registra: begin
        registraR = 1'b1;
      end
      proximo: begin
        contaC = 1'b1;
      end
      fim_acerto: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      fim_erro: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      fim_timeout: begin
        pronto      = 1'b1;
        deu_timeout = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Bench for exp5_unidade_controle. Each round is described by its plays
// (delay per play, miss / timeout / reset position). From that description an
// expected per-cycle trace of display codes is generated. The trace is then
// replayed against the DUT, with don't-care inputs randomised.
module tb_exp5_unidade_controle;

  localparam int TMO = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       deu_timeout;
  logic [3:0] db_estado;

  exp5_unidade_controle #(.TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .jogada      (jogada),
    .igual       (igual),
    .fim         (fim),
    .zeraC       (zeraC),
    .contaC      (contaC),
    .zeraR       (zeraR),
    .registraR   (registraR),
    .pronto      (pronto),
    .acertou     (acertou),
    .errou       (errou),
    .deu_timeout (deu_timeout),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // One entry per clock cycle: the inputs driven during the cycle and the
  // display code the DUT must show during that same cycle.
  typedef struct {
    logic       rst;
    logic       ini;
    logic       jog;
    logic       ig;
    logic       fi;
    logic [3:0] st;
  } cyc_t;

  cyc_t       prog[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_reg;
  int         exp_cnt;
  logic [3:0] cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs for a display code:
  // {code, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, deu_timeout}.
  function automatic logic [11:0] expected_view(input logic [3:0] st);
    logic [7:0] o;
    o = 8'b0;
    case (st)
      4'h1: o = 8'b1010_0000;
      4'h4: o = 8'b0001_0000;
      4'h6: o = 8'b0100_0000;
      4'hA: o = 8'b0000_1100;
      4'hE: o = 8'b0000_1010;
      4'hD: o = 8'b0000_1001;
      default: o = 8'b0;
    endcase
    return {st, o};
  endfunction

  function automatic logic [11:0] dut_view();
    return {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, deu_timeout};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic add(input logic [3:0] st, input logic ini, input logic jog,
                     input logic ig, input logic fi, input logic rst);
    cyc_t c;
    c.st  = st;
    c.ini = ini;
    c.jog = jog;
    c.ig  = ig;
    c.fi  = fi;
    c.rst = rst;
    prog.push_back(c);
  endtask

  // n plays; miss/to/rst_at are play indexes (-1 = never); dly < 0 picks a
  // random delay per play; hold = cycles to stay in the final state.
  task automatic gen_round(input int n, input int miss, input int to, input int rst_at,
                           input int dly, input int hold);
    logic [3:0] fin;
    bit         done;
    int         d;
    fin  = 4'h0;
    done = 0;
    exp_reg = 0;
    exp_cnt = 0;
    add(cur, 1'b1, rb(), rb(), rb(), 1'b1);
    add(4'h1, rb(), rb(), rb(), rb(), 1'b1);
    for (int i = 0; i < n && !done; i++) begin
      if (i == to) begin
        repeat (TMO) add(4'h2, rb(), 1'b0, rb(), rb(), 1'b1);
        fin  = 4'hD;
        done = 1;
      end else begin
        d = (dly < 0) ? int'($urandom_range(TMO - 1, 0)) : dly;
        repeat (d) add(4'h2, rb(), 1'b0, rb(), rb(), 1'b1);
        add(4'h2, rb(), 1'b1, rb(), rb(), 1'b1);
        add(4'h4, rb(), rb(), rb(), rb(), 1'b1);
        exp_reg++;
        add(4'h5, rb(), rb(), (i != miss), (i == n - 1), (i == rst_at) ? 1'b0 : 1'b1);
        if (i == rst_at) begin
          fin  = 4'h0;
          done = 1;
        end else if (i == miss) begin
          fin  = 4'hE;
          done = 1;
        end else if (i == n - 1) begin
          fin  = 4'hA;
          done = 1;
        end else begin
          add(4'h6, rb(), rb(), rb(), rb(), 1'b1);
          exp_cnt++;
        end
      end
    end
    repeat (hold) add(fin, 1'b0, rb(), rb(), rb(), 1'b1);
    cur = fin;
  endtask

  task automatic run_prog(input string name);
    int obs_reg;
    int obs_cnt;
    int k;
    obs_reg = 0;
    obs_cnt = 0;
    k = 0;
    foreach (prog[i]) begin
      check($sformatf("%s cyc%0d", name, k), dut_view(), expected_view(prog[i].st));
      if (registraR === 1'b1) obs_reg++;
      if (contaC === 1'b1) obs_cnt++;
      reset   = prog[i].rst;
      iniciar = prog[i].ini;
      jogada  = prog[i].jog;
      igual   = prog[i].ig;
      fim     = prog[i].fi;
      @(posedge clock);
      #1;
      k++;
    end
    prog.delete();
    check($sformatf("%s n_registraR", name), obs_reg, exp_reg);
    check($sformatf("%s n_contaC", name), obs_cnt, exp_cnt);
  endtask

  initial begin
    int n;
    int miss;
    int to;
    int ra;
    reset   = 1'b0;
    iniciar = 1'b0;
    jogada  = 1'b0;
    igual   = 1'b0;
    fim     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset", dut_view(), expected_view(4'h0));

    // Idle with iniciar low.
    cur = 4'h0;
    exp_reg = 0;
    exp_cnt = 0;
    repeat (10) add(4'h0, 1'b0, rb(), rb(), rb(), 1'b1);
    run_prog("idle");

    gen_round(16, -1, -1, -1, -1, 4);
    run_prog("full16");
    gen_round(5, 2, -1, -1, -1, 3);
    run_prog("miss3");
    // Restart straight out of fim_erro into a round that times out.
    gen_round(1, -1, 0, -1, -1, 3);
    run_prog("timeout");
    // Plays on the last wait cycle, then a fresh full wait after proximo.
    gen_round(3, -1, 2, -1, TMO - 1, 2);
    run_prog("tmo_edge");
    gen_round(4, -1, -1, 1, -1, 3);
    run_prog("mid_reset");

    for (int r = 0; r < 30; r++) begin
      n    = int'($urandom_range(6, 1));
      miss = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      to   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      ra   = ($urandom_range(7, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      gen_round(n, miss, to, ra, -1, int'($urandom_range(3, 1)));
      run_prog($sformatf("rnd%0d", r));
    end

    exp_reg = 0;
    exp_cnt = 0;
    add(cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_prog("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exp5_unidade_controle.md
# exp5_unidade_controle

Moore control unit that sequences the memory-game datapath (address counter, play register, comparator, memory) for one round: it clears the datapath, waits for each play, registers and compares it against memory, advances the address, and ends in hit, miss or timeout. It also owns the per-play timeout counter, so the datapath needs no timeout logic. It sits beside the datapath inside the top-level circuit, and its `db_estado` output drives the HEX5 state display.

## Interface
- `TIMEOUT`, default 5000: maximum number of cycles spent waiting for a play (5 s at 1 kHz); must be ≥ 2.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `iniciar` in 1: start/restart request, level.
- `jogada` in 1: one-cycle pulse from the datapath edge detector, meaning a play was made.
- `igual` in 1: comparator result, switches vs. memory at the current address.
- `fim` in 1: address counter is at its last position.
- `zeraC` out 1: clear the address counter.
- `contaC` out 1: increment the address counter.
- `zeraR` out 1: clear the play register.
- `registraR` out 1: load the play register.
- `pronto` out 1: round finished.
- `acertou` out 1: round ended with every play correct.
- `errou` out 1: round ended on a wrong play.
- `deu_timeout` out 1: round ended on a timeout.
- `db_estado` out 4: encoded current state, for the debug display.

## Operation
- States and `db_estado` codes:
  - inicial = 0
  - preparacao = 1
  - espera_jogada = 2
  - registra = 4
  - comparacao = 5
  - proximo = 6
  - fim_acerto = A
  - fim_erro = E
  - fim_timeout = D
- Any other state code recovers to inicial on the next edge.
- Transitions:
  - inicial: `iniciar`=1 → preparacao; otherwise stay.
  - preparacao: → espera_jogada unconditionally.
  - espera_jogada: `jogada`=1 → registra. Otherwise, timeout counter = `TIMEOUT`-1 → fim_timeout. Otherwise stay. `jogada` wins over timeout in the same cycle.
  - registra: → comparacao.
  - comparacao:
    - `igual`=0 → fim_erro.
    - `igual`=1 and `fim`=1 → fim_acerto.
    - `igual`=1 and `fim`=0 → proximo.
  - proximo: → espera_jogada.
  - fim_acerto, fim_erro, fim_timeout: `iniciar`=1 → preparacao (restart); otherwise hold.
- `iniciar` is ignored in preparacao, espera_jogada, registra, comparacao and proximo.
- `jogada` is ignored outside espera_jogada.
- Outputs are decoded purely from the state (Moore):
  - preparacao: `zeraC`=`zeraR`=1.
  - registra: `registraR`=1.
  - proximo: `contaC`=1.
  - fim_acerto: `pronto`=`acertou`=1.
  - fim_erro: `pronto`=`errou`=1.
  - fim_timeout: `pronto`=`deu_timeout`=1.
  - All other outputs are 0 in every state.
- Timeout counter:
  - Width is ceil(log2(`TIMEOUT`)) bits.
  - Cleared to 0 in every state other than espera_jogada.
  - Increments by 1 on each cycle spent in espera_jogada.
  - Never wraps, because the state exits at `TIMEOUT`-1.

## Timing
- Reset (`reset`=0 at an edge):
  - State → inicial and timeout counter → 0.
  - All control and result outputs are 0; `db_estado`=0.
  - Reset overrides every other input, including in the middle of a round.
- All state changes occur on rising edges of `clock`; outputs change only after an edge.
- Play handling:
  - `jogada` sampled high in espera_jogada gives `registraR`=1 in the very next cycle.
  - `igual` is sampled in comparacao, one cycle after `registraR`, once the register holds the play.
- Overhead per correct, non-final play is 3 cycles: registra, comparacao, proximo.
- Start latency: `iniciar` sampled in inicial gives `zeraC`/`zeraR` in the next cycle, then espera_jogada one cycle after that.
- With no `jogada`, espera_jogada lasts exactly `TIMEOUT` cycles; `deu_timeout` rises on the following edge.
- `jogada` in the final wait cycle (counter = `TIMEOUT`-1) is accepted as a play, not a timeout.
- Final-state outputs hold indefinitely until `iniciar` or reset.

## Test plan
- Reset and idle: hold `reset`=0 for 2 cycles, then 1 with `iniciar`=0 for 10 cycles → `db_estado`=0 and all outputs 0 throughout.
- Full correct round (`TIMEOUT`=8, 16 addresses):
  - Stimulus: pulse `iniciar`; 16 `jogada` pulses with `igual`=1; `fim`=1 only on the 16th.
  - Required: `zeraC`/`zeraR` for exactly 1 cycle; 16 `registraR` pulses; 15 `contaC` pulses; then `pronto`=`acertou`=1 and `db_estado`=A, held.
- Miss on the 3rd play (`igual`=0 in that comparacao) → 2 `contaC` pulses, then `pronto`=`errou`=1 and `db_estado`=E; `acertou`=0.
- Timeout (`TIMEOUT`=8): start the round, never pulse `jogada` → 8 cycles with `db_estado`=2, then `deu_timeout`=`pronto`=1 and `db_estado`=D.
- Timeout edge and counter clear:
  - `jogada` on the 8th wait cycle → registra, no timeout.
  - After proximo, a fresh 8-cycle wait applies before timeout (counter cleared).
- Restart and mid-round reset:
  - `iniciar` in fim_erro → preparacao, and the outputs clear.
  - `reset`=0 during comparacao → inicial on the next edge, outputs 0.
  - `iniciar` pulsed during espera_jogada → ignored.
